// File: rtl/frq_div_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
package frq_div_pkg;

    localparam int FRQ_DIV_WIDTH_DEF    = 8;
    localparam int FRQ_DIV_CHANNELS_DEF = 4;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frq_div_channel.sv
// One divider channel: load register, up-counter, terminal pulse and optional square stage.
// Square stage is built only when MULTI_FRQ_DIV_SQUARE_EN is defined.
module frq_div_channel
    import frq_div_pkg::*;
#(
    parameter int WIDTH = FRQ_DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic             co,
    output logic             sq
);

    logic [WIDTH-1:0] lv_q, lv_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             co_q, co_d;

    always_comb begin
        lv_d  = lv_q;
        cnt_d = cnt_q;
        co_d  = 1'b0;
        if (ld) begin
            lv_d  = ld_val;
            cnt_d = ld_val;
        end else if (en) begin
            // Terminal count reloads from lv, so lv = all-ones pulses every cycle.
            if (cnt_q == {WIDTH{1'b1}}) begin
                cnt_d = lv_q;
                co_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lv_q  <= '0;
            cnt_q <= '0;
            co_q  <= 1'b0;
        end else begin
            lv_q  <= lv_d;
            cnt_q <= cnt_d;
            co_q  <= co_d;
        end
    end

    assign co = co_q;

`ifdef MULTI_FRQ_DIV_SQUARE_EN
    logic sq_q, sq_d;

    // A load freezes the square phase for that cycle.
    always_comb begin
        sq_d = ld ? sq_q : (sq_q ^ co_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/multi_frq_div.sv
// Multi-channel programmable divider: load decode, channel array and output mux.
// MULTI_FRQ_DIV_SQUARE_EN enables the per-channel square outputs and the sel mux leg.
module multi_frq_div
    import frq_div_pkg::*;
#(
    parameter int WIDTH    = FRQ_DIV_WIDTH_DEF,
    parameter int CHANNELS = FRQ_DIV_CHANNELS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              ld,
    input  logic [ch_idx_w(CHANNELS)-1:0]     ld_ch,
    input  logic [WIDTH-1:0]                  ld_val,
    input  logic [ch_idx_w(CHANNELS)-1:0]     out_ch,
    input  logic                              sel,
    output logic [CHANNELS-1:0]               co,
    output logic [CHANNELS-1:0]               sq,
    output logic                              out
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    logic [CHANNELS-1:0] ld_dec;

    // Out-of-range channel indices match no channel, so they load nothing.
    always_comb begin
        ld_dec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ld_dec[i] = ld && (ld_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        frq_div_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .ld     (ld_dec[g]),
            .ld_val (ld_val),
            .co     (co[g]),
            .sq     (sq[g])
        );
    end

`ifdef MULTI_FRQ_DIV_SQUARE_EN
    always_comb begin
        out = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (out_ch == CH_W'(i)) out = sel ? sq[i] : co[i];
        end
    end
`else
    logic sel_unused;
    assign sel_unused = sel;

    always_comb begin
        out = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (out_ch == CH_W'(i)) out = co[i];
        end
    end
`endif

endmodule

// File: tb/tb_multi_frq_div.sv
// Scoreboard bench for multi_frq_div (WIDTH=4, CHANNELS=2) against a cycles-remaining model.
module tb_multi_frq_div;

    localparam int W  = 4;
    localparam int NC = 2;
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         ld = 1'b0;
    logic [0:0]   ld_ch = '0;
    logic [W-1:0] ld_val = '0;
    logic [0:0]   out_ch = '0;
    logic         sel = 1'b0;
    logic [NC-1:0] co;
    logic [NC-1:0] sq;
    logic          out;

    multi_frq_div #(.WIDTH(W), .CHANNELS(NC)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ld     (ld),
        .ld_ch  (ld_ch),
        .ld_val (ld_val),
        .out_ch (out_ch),
        .sel    (sel),
        .co     (co),
        .sq     (sq),
        .out    (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] co;
        logic [NC-1:0] sq;
        logic          o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: per channel, load value and enabled edges left until the next pulse.
    int rem[NC];
    int lvm[NC];
    bit com[NC];
    bit sqm[NC];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NC; i++) begin
            bit loading;
            bit nco;
            bit nsq;
            if (!rst) begin
                lvm[i] = 0; rem[i] = M; com[i] = 0; sqm[i] = 0;
            end else begin
                loading = ld && (int'(ld_ch) == i);
                nco = 0;
                nsq = sqm[i];
`ifdef MULTI_FRQ_DIV_SQUARE_EN
                if (!loading) nsq = sqm[i] ^ com[i];
`endif
                if (loading) begin
                    lvm[i] = int'(ld_val);
                    rem[i] = M - lvm[i];
                end else if (en) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        nco = 1;
                        rem[i] = M - lvm[i];
                    end
                end
                com[i] = nco;
                sqm[i] = nsq;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < NC; i++) begin
            e.co[i] = com[i];
            e.sq[i] = sqm[i];
        end
`ifdef MULTI_FRQ_DIV_SQUARE_EN
        e.o = sel ? sqm[out_ch] : com[out_ch];
`else
        e.o = com[out_ch];
`endif
        exp_q.push_back(e);
    endtask

    // Inputs applied here are held across the next rising edge.
    task automatic drive(input logic r, input logic e, input logic l, input int lc,
                         input int lvv, input int oc, input logic s);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; en = e; ld = l; ld_ch = 1'(lc); ld_val = W'(lvv);
        out_ch = 1'(oc); sel = s;
        push_exp();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) drive(1, 1, 0, 0, 0, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("co", int'(co), int'(e.co));
                check("sq", int'(sq), int'(e.sq));
                check("out", int'(out), int'(e.o));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        // Reset with a load pending: reset must win.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 9, i % 2, 1'(i));
        drive(1, 1, 0, 0, 0, 0, 0);
        run(34);
        drive(1, 1, 1, 0, 12, 0, 1);
        run(20);
        drive(1, 1, 1, 1, 15, 1, 1);
        run(10);
        // Reload ch0 exactly at its terminal count.
        k = 0;
        while (rem[0] != 1 && k < 20) begin
            run(1);
            k++;
        end
        check("tc_reach", int'(rem[0] == 1), 1);
        drive(1, 1, 1, 0, 13, 0, 0);
        run(10);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1);
        run(10);
        drive(0, 1, 0, 0, 0, 1, 1);
        run(5);
        drive(1, 1, 1, 0, 14, 0, 0);
        drive(1, 1, 1, 1, 13, 0, 0);
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 0, c / 2, 1'(c % 2));
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                  $urandom_range(0, M - 1), $urandom_range(0, 1),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
